// File: rtl/hoplite_rt_pkg.sv
// Shared constants and width helpers for the hoplite injection policer.
package hoplite_rt_pkg;

    localparam logic MODE_FLAG = 1'b0;
    localparam logic MODE_DROP = 1'b1;

    function automatic int rate_w(input int max_rate);
        return (max_rate <= 2) ? 1 : $clog2(max_rate);
    endfunction

    function automatic int tok_w(input int max_token);
        return (max_token <= 1) ? 1 : $clog2(max_token + 1);
    endfunction

endpackage

// File: rtl/policer_bucket.sv
// Shadow token bucket: free-running refill phase plus token count.
module policer_bucket
    import hoplite_rt_pkg::*;
#(
    parameter int MAX_RATE  = 4,
    parameter int MAX_TOKEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic conf_i,
    output logic has_token_o
);

    localparam int R_W = rate_w(MAX_RATE);
    localparam int T_W = tok_w(MAX_TOKEN);
    localparam logic [R_W-1:0] RATE_LAST = R_W'(MAX_RATE - 1);
    localparam logic [T_W-1:0] TOK_MAX   = T_W'(MAX_TOKEN);

    logic [R_W-1:0] rate_q, rate_d;
    logic [T_W-1:0] tok_q, tok_d;
    logic           refill;

    always_comb begin
        refill = (rate_q == RATE_LAST);
        rate_d = refill ? '0 : rate_q + 1'b1;
        tok_d  = tok_q;
        // a refill in the same cycle as a consume leaves the count unchanged
        if (refill && !conf_i && tok_q != TOK_MAX)
            tok_d = tok_q + 1'b1;
        else if (!refill && conf_i)
            tok_d = tok_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q <= '0;
            tok_q  <= TOK_MAX;
        end else begin
            rate_q <= rate_d;
            tok_q  <= tok_d;
        end
    end

    assign has_token_o = (tok_q != '0);

endmodule

// File: rtl/hoplite_policer.sv
// Ingress conformance policer: one register stage, tag/drop of
// non-conforming packets, saturating pass/violation statistics.
module hoplite_policer
    import hoplite_rt_pkg::*;
#(
    parameter int MAX_RATE  = 4,
    parameter int MAX_TOKEN = 2,
    parameter int DATA_W    = 64,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_drop,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_nonconf,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  viol_cnt,
    output logic              viol_sticky
);

    logic              acc, conf, nonconf, load, has_token;
    logic              vld_q, vld_d;
    logic              nc_q, nc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  pass_q, pass_d;
    logic [CNT_W-1:0]  viol_q, viol_d;
    logic              sticky_q, sticky_d;

    policer_bucket #(
        .MAX_RATE  (MAX_RATE),
        .MAX_TOKEN (MAX_TOKEN)
    ) u_bucket (
        .clk         (clk),
        .rst         (rst),
        .conf_i      (conf),
        .has_token_o (has_token)
    );

    assign in_ready = !vld_q || out_ready;
    assign acc      = in_valid && in_ready;
    assign conf     = acc && has_token;
    assign nonconf  = acc && !has_token;
    assign load     = conf || (nonconf && cfg_drop == MODE_FLAG);

    always_comb begin
        vld_d  = vld_q;
        nc_d   = nc_q;
        data_d = data_q;
        if (load) begin
            vld_d  = 1'b1;
            nc_d   = nonconf;
            data_d = in_data;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    // clear first, then count the same-cycle event on top of it
    always_comb begin
        pass_d   = clr_stats ? '0 : pass_q;
        viol_d   = clr_stats ? '0 : viol_q;
        sticky_d = clr_stats ? 1'b0 : sticky_q;
        if (conf && pass_d != '1)
            pass_d = pass_d + 1'b1;
        if (nonconf) begin
            sticky_d = 1'b1;
            if (viol_d != '1)
                viol_d = viol_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= 1'b0;
            nc_q     <= 1'b0;
            data_q   <= '0;
            pass_q   <= '0;
            viol_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            nc_q     <= nc_d;
            data_q   <= data_d;
            pass_q   <= pass_d;
            viol_q   <= viol_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid   = vld_q;
    assign out_nonconf = nc_q;
    assign out_data    = data_q;
    assign pass_cnt    = pass_q;
    assign viol_cnt    = viol_q;
    assign viol_sticky = sticky_q;

endmodule

// File: tb/tb_hoplite_policer.sv
// Scoreboard bench for hoplite_policer (MAX_RATE=4, MAX_TOKEN=2);
// a CNT_W=2 twin shares the stimulus for saturation checks.
module tb_hoplite_policer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_drop = 1'b0;
    logic        clr_stats = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_nonconf, viol_sticky;
    logic [63:0] out_data;
    logic [15:0] pass_cnt, viol_cnt;

    logic        in_ready2, out_valid2, out_nonconf2, viol_sticky2;
    logic [63:0] out_data2;
    logic [1:0]  pass_cnt2, viol_cnt2;

    typedef struct packed {
        logic [63:0] data;
        logic        nc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hoplite_policer #(.MAX_RATE(4), .MAX_TOKEN(2), .DATA_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_drop(cfg_drop), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nonconf(out_nonconf), .pass_cnt(pass_cnt), .viol_cnt(viol_cnt),
        .viol_sticky(viol_sticky)
    );

    hoplite_policer #(.MAX_RATE(4), .MAX_TOKEN(2), .DATA_W(64), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_drop(cfg_drop), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_nonconf(out_nonconf2), .pass_cnt(pass_cnt2), .viol_cnt(viol_cnt2),
        .viol_sticky(viol_sticky2)
    );

    // a transfer seen at the negedge completes on the following posedge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out: got data=%h nonconf=%b, required no output",
                         out_data, out_nonconf);
            end else begin
                e = sb.pop_front();
                if ({out_data, out_nonconf} !== {e.data, e.nc}) begin
                    miscompares++;
                    $display("FAIL out_pkt: got data=%h nonconf=%b, required data=%h nonconf=%b",
                             out_data, out_nonconf, e.data, e.nc);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        clr_stats = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cfg_drop = 1'b0;
        out_ready = 1'b1;
        do_reset();
        vectors++;
        if ({out_valid, out_nonconf, out_data, pass_cnt, viol_cnt, viol_sticky} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b nc=%b d=%h p=%0d vi=%0d s=%b, required all zero",
                     out_valid, out_nonconf, out_data, pass_cnt, viol_cnt, viol_sticky);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_flag_burst();
        logic nc_pat [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        cfg_drop = 1'b0;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 64'hA000 + 64'(i);
            sb.push_back('{data: in_data, nc: nc_pat[i]});
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL flag_in_ready[%0d]: got %b, required 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        vectors++;
        if (pass_cnt !== 16'd3 || viol_cnt !== 16'd2 || viol_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL flag_stats: got p=%0d v=%0d s=%b, required p=3 v=2 s=1",
                     pass_cnt, viol_cnt, viol_sticky);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL flag_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_drop_burst();
        logic nc_pat [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        cfg_drop = 1'b1;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 64'hB000 + 64'(i);
            if (!nc_pat[i])
                sb.push_back('{data: in_data, nc: 1'b0});
            tick();
            vectors++;
            if (viol_sticky !== (i >= 2)) begin
                miscompares++;
                $display("FAIL drop_sticky[%0d]: got %b, required %b", i, viol_sticky, (i >= 2));
            end
        end
        in_valid = 1'b0;
        repeat (2) tick();
        vectors++;
        if (pass_cnt !== 16'd3 || viol_cnt !== 16'd2 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL drop_stats: got p=%0d v=%0d pend=%0d, required p=3 v=2 pend=0",
                     pass_cnt, viol_cnt, sb.size());
        end
        cfg_drop = 1'b0;
    endtask

    task automatic test_refill_idle();
        logic nc_pat [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic nc_b [3] = '{1'b0, 1'b0, 1'b1};
        cfg_drop = 1'b0;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 64'hC000 + 64'(i);
            sb.push_back('{data: in_data, nc: nc_pat[i]});
            tick();
        end
        in_valid = 1'b0;
        repeat (19) tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 64'hC100 + 64'(i);
            sb.push_back('{data: in_data, nc: nc_b[i]});
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        vectors++;
        if (pass_cnt !== 16'd5 || viol_cnt !== 16'd3 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL idle_stats: got p=%0d v=%0d pend=%0d, required p=5 v=3 pend=0",
                     pass_cnt, viol_cnt, sb.size());
        end
    endtask

    task automatic test_stall();
        cfg_drop = 1'b0;
        out_ready = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_data = 64'hD0D0;
        sb.push_back('{data: in_data, nc: 1'b0});
        tick();
        in_data = 64'hDEAD;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'hD0D0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got rdy=%b v=%b d=%h, required rdy=0 v=1 d=d0d0",
                         i, in_ready, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL stall_release: got v=%b pend=%0d, required v=0 pend=0",
                     out_valid, sb.size());
        end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = 64'hD100 + 64'(i);
            sb.push_back('{data: in_data, nc: 1'b0});
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        vectors++;
        if (pass_cnt !== 16'd3 || viol_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL stall_stats: got p=%0d v=%0d, required p=3 v=0", pass_cnt, viol_cnt);
        end
    endtask

    task automatic test_saturation_clear();
        cfg_drop = 1'b1;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data = 64'hE000 + 64'(i);
            if (i == 0 || i == 1 || i == 4 || i == 8)
                sb.push_back('{data: in_data, nc: 1'b0});
            tick();
        end
        in_data = 64'hE0FF;
        sb.push_back('{data: in_data, nc: 1'b0});
        vectors++;
        if (pass_cnt !== 16'd4 || viol_cnt !== 16'd8) begin
            miscompares++;
            $display("FAIL sat_wide: got p=%0d v=%0d, required p=4 v=8", pass_cnt, viol_cnt);
        end
        vectors++;
        if (pass_cnt2 !== 2'd3 || viol_cnt2 !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_narrow: got p=%0d v=%0d, required p=3 v=3", pass_cnt2, viol_cnt2);
        end
        tick();
        in_data = 64'hE1FF;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (viol_cnt !== 16'd1 || pass_cnt !== 16'd0 || viol_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_event: got p=%0d v=%0d s=%b, required p=0 v=1 s=1",
                     pass_cnt, viol_cnt, viol_sticky);
        end
        vectors++;
        if (viol_cnt2 !== 2'd1) begin
            miscompares++;
            $display("FAIL clr_event_narrow: got v=%0d, required v=1", viol_cnt2);
        end
        repeat (2) tick();
        cfg_drop = 1'b0;
    endtask

    task automatic test_reset_midpacket();
        cfg_drop = 1'b0;
        out_ready = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_data = 64'hF0F0;
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_nonconf !== 1'b0 || pass_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL midpkt_reset: got v=%b nc=%b p=%0d, required v=0 nc=0 p=0",
                     out_valid, out_nonconf, pass_cnt);
        end
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 64'hF1F1;
        sb.push_back('{data: in_data, nc: 1'b0});
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        vectors++;
        if (pass_cnt !== 16'd1 || viol_cnt !== 16'd0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL midpkt_after: got p=%0d v=%0d pend=%0d, required p=1 v=0 pend=0",
                     pass_cnt, viol_cnt, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_flag_burst();
        test_drop_burst();
        test_refill_idle();
        test_stall();
        test_saturation_clear();
        test_reset_midpacket();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
